// File: rtl/apb_rr_master.sv
// Round-robin APB master: N_REQ valid/ready command ports share one APB
// slave port, with wait states, pready timeout and a one-cycle response.
//
// Ports:
//   pclk, preset        clock, synchronous active-high reset
//   req_valid/ready     per-requester command handshake (ready one-hot)
//   req_write/addr/wdata per-requester command, 32-bit lanes packed by index
//   rsp_valid           one-cycle pulse to the granted requester
//   rsp_rdata/rsp_err   read data (0 on write/error), error flag
//   busy, err_cnt       non-IDLE flag, saturating error count
//   psel..prdata        APB master port
module apb_rr_master #(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ-1:0]      req_write,
    input  logic [32*N_REQ-1:0]   req_addr,
    input  logic [32*N_REQ-1:0]   req_wdata,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [7:0]            err_cnt,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [31:0]           paddr,
    output logic [31:0]           pwdata,
    input  logic                  pready,
    input  logic                  pslverr,
    input  logic [31:0]           prdata
);

    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [GW-1:0] LAST = GW'(N_REQ - 1);
    localparam logic [CW-1:0] TMO  = CW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [GW-1:0]   last_q;
    logic [GW-1:0]   last_d;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   grant_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            pwrite_d;
    logic [31:0]     paddr_d;
    logic [31:0]     pwdata_d;
    logic [31:0]     rdata_d;
    logic            err_d;
    logic [7:0]      errc_d;

    logic            found;
    logic [GW-1:0]   sel;
    logic [GW-1:0]   cand;

    // Rotating search starting just after the previous winner.
    always_comb begin
        found = 1'b0;
        sel   = last_q;
        cand  = last_q;
        for (int i = 0; i < N_REQ; i++) begin
            cand = (cand == LAST) ? '0 : cand + GW'(1);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        pwrite_d  = pwrite;
        paddr_d   = paddr;
        pwdata_d  = pwdata;
        rdata_d   = rsp_rdata;
        err_d     = rsp_err;
        errc_d    = err_cnt;
        req_ready = '0;
        rsp_valid = '0;
        psel      = 1'b0;
        penable   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (found && !preset) begin
                    req_ready[sel] = 1'b1;
                    last_d   = sel;
                    grant_d  = sel;
                    pwrite_d = req_write[sel];
                    paddr_d  = req_addr[32*sel +: 32];
                    pwdata_d = req_write[sel]
                             ? req_wdata[32*sel +: 32]
                             : '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                psel    = 1'b1;
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                // pready wins over the timeout in the same cycle.
                if (pready) begin
                    err_d   = pslverr;
                    rdata_d = (!pwrite && !pslverr) ? prdata : '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == TMO) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                rsp_valid[grant_q] = 1'b1;
                if (rsp_err && err_cnt != 8'hFF) begin
                    errc_d = err_cnt + 8'd1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q   <= IDLE;
            last_q    <= LAST;
            grant_q   <= '0;
            cnt_q     <= '0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            pwrite    <= pwrite_d;
            paddr     <= paddr_d;
            pwdata    <= pwdata_d;
            rsp_rdata <= rdata_d;
            rsp_err   <= err_d;
            err_cnt   <= errc_d;
        end
    end

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master with a response scoreboard.
// Stimulus pushes expected responses; a monitor pops them on rsp_valid.
module tb_apb_rr_master;

    localparam int N   = 2;
    localparam int TMO = 16;

    logic            pclk = 1'b0;
    logic            preset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_write = '0;
    logic [32*N-1:0] req_addr = '0;
    logic [32*N-1:0] req_wdata = '0;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;
    logic            busy;
    logic [7:0]      err_cnt;
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [31:0]     paddr;
    logic [31:0]     pwdata;
    logic            pready;
    logic            pslverr;
    logic [31:0]     prdata;

    int n_vec = 0;
    int n_bad = 0;

    always #5 pclk = ~pclk;

    apb_rr_master #(
        .N_REQ       (N),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .err_cnt   (err_cnt),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .prdata    (prdata)
    );

    // APB slave: pready in ACCESS cycle wait_k, unless never is set.
    int          wait_k = 1;
    int          acc_n = 0;
    logic        never = 1'b0;
    logic        err_val = 1'b0;
    logic        stale_err = 1'b0;
    logic [31:0] rd_val = '0;

    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_n <= acc_n + 1;
        else acc_n <= 0;
    end

    assign pready  = psel && penable && !never && (acc_n == wait_k - 1);
    assign pslverr = pready ? err_val : stale_err;
    assign prdata  = rd_val;

    typedef struct {
        logic [N-1:0] who;
        logic [31:0]  rdata;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic push_exp(input logic [N-1:0] who,
                            input logic [31:0] rdata, input logic err);
        exp_t e;
        e.who   = who;
        e.rdata = rdata;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    always @(negedge pclk) begin
        if (!preset && rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_rsp: got rsp_valid=%b, required none",
                         rsp_valid);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_valid", 64'(rsp_valid), 64'(mon_e.who));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
                chk("rsp_err", 64'(rsp_err), 64'(mon_e.err));
            end
        end
    end

    // Called at a negedge; returns at the negedge of the SETUP cycle.
    task automatic send(input int i, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        req_write[i]         = w;
        req_addr[32*i +: 32]  = a;
        req_wdata[32*i +: 32] = d;
        req_valid[i]         = 1'b1;
        #1;
        while (!req_ready[i] && n < 100) begin
            @(negedge pclk);
            #1;
            n++;
        end
        chk("accept", 64'(req_ready[i]), 64'(1));
        @(negedge pclk);
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge pclk);
            n++;
        end
        chk("idle", 64'(busy), 64'(0));
    endtask

    task automatic do_reset();
        preset = 1'b1;
        repeat (2) @(negedge pclk);
        preset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] exp_rdy;
        int           n;
        int           pen;

        // Reset values, req_ready blocked during reset.
        req_valid = 2'b11;
        repeat (2) @(negedge pclk);
        #1;
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_psel", 64'({psel, penable, pwrite}), 64'(0));
        chk("rst_paddr", 64'(paddr), 64'(0));
        chk("rst_pwdata", 64'(pwdata), 64'(0));
        chk("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
        chk("rst_errcnt", 64'(err_cnt), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        @(negedge pclk);
        req_valid = '0;
        preset    = 1'b0;

        // Req0 write, pready in 2nd ACCESS cycle.
        wait_k = 2;
        push_exp(2'b01, 32'h0, 1'b0);
        send(0, 1'b1, 32'h0, 32'hDEADBEEF);
        chk("t1_setup", 64'({psel, penable, pwrite}), 64'(3'b101));
        chk("t1_paddr", 64'(paddr), 64'(0));
        chk("t1_pwdata", 64'(pwdata), 64'(32'hDEADBEEF));
        @(negedge pclk);
        chk("t1_acc1", 64'({psel, penable}), 64'(2'b11));
        @(negedge pclk);
        chk("t1_acc2", 64'({psel, penable}), 64'(2'b11));
        @(negedge pclk);
        chk("t1_resp_at_t4", 64'(rsp_valid), 64'(2'b01));
        chk("t1_resp_psel", 64'(psel), 64'(0));
        @(negedge pclk);
        chk("t1_idle", 64'({busy, rsp_valid}), 64'(0));

        // Req1 read, pready in 1st ACCESS cycle.
        wait_k = 1;
        rd_val = 32'h5555_5555;
        push_exp(2'b10, 32'h5555_5555, 1'b0);
        send(1, 1'b0, 32'h4, 32'hFFFF_FFFF);
        chk("t2_paddr", 64'(paddr), 64'(4));
        chk("t2_pwrite", 64'(pwrite), 64'(0));
        chk("t2_pwdata", 64'(pwdata), 64'(0));
        wait_idle();

        // Slave error, then good transfer with stale pslverr.
        err_val = 1'b1;
        rd_val  = 32'h1234_5678;
        push_exp(2'b01, 32'h0, 1'b1);
        send(0, 1'b0, 32'h10, 32'h0);
        wait_idle();
        chk("t3_errcnt", 64'(err_cnt), 64'(1));
        err_val   = 1'b0;
        stale_err = 1'b1;
        wait_k    = 2;
        rd_val    = 32'hA5A5_A5A5;
        push_exp(2'b01, 32'hA5A5_A5A5, 1'b0);
        send(0, 1'b0, 32'h14, 32'h0);
        wait_idle();
        chk("t3_stale_errcnt", 64'(err_cnt), 64'(1));
        stale_err = 1'b0;

        // Both requesters held: strict rotation from requester 0.
        do_reset();
        chk("t4_errcnt_rst", 64'(err_cnt), 64'(0));
        wait_k    = 1;
        rd_val    = 32'h0BAD_F00D;
        req_write = '0;
        req_addr  = {32'h200, 32'h100};
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            #1;
            while (req_ready == '0 && n < 100) begin
                @(negedge pclk);
                #1;
                n++;
            end
            exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
            chk("t4_rr_ready", 64'(req_ready), 64'(exp_rdy));
            push_exp(exp_rdy, 32'h0BAD_F00D, 1'b0);
            @(negedge pclk);
            if (k == 3) req_valid = '0;
            chk("t4_paddr", 64'(paddr),
                64'((k % 2 == 0) ? 32'h100 : 32'h200));
        end
        wait_idle();

        // Timeout: no pready.
        never = 1'b1;
        push_exp(2'b10, 32'h0, 1'b1);
        send(1, 1'b1, 32'h20, 32'h11);
        @(negedge pclk);
        pen = 0;
        while (penable && pen < 100) begin
            pen++;
            @(negedge pclk);
        end
        chk("t5_pen_cycles", 64'(pen), 64'(TMO));
        chk("t5_resp_psel", 64'({psel, rsp_valid}), 64'(3'b010));
        wait_idle();
        chk("t5_errcnt", 64'(err_cnt), 64'(1));
        never = 1'b0;

        // pready exactly at the timeout limit is a normal completion.
        wait_k = TMO;
        rd_val = 32'hCAFE_F00D;
        push_exp(2'b01, 32'hCAFE_F00D, 1'b0);
        send(0, 1'b0, 32'h24, 32'h0);
        @(negedge pclk);
        pen = 0;
        while (penable && pen < 100) begin
            pen++;
            @(negedge pclk);
        end
        chk("t5b_pen_cycles", 64'(pen), 64'(TMO));
        wait_idle();
        chk("t5b_errcnt", 64'(err_cnt), 64'(1));

        // Reset in 2nd ACCESS cycle drops the command.
        wait_k = 5;
        send(0, 1'b1, 32'h30, 32'h77);
        @(negedge pclk);
        @(negedge pclk);
        preset = 1'b1;
        @(negedge pclk);
        preset = 1'b0;
        chk("t6_apb_off", 64'({psel, penable}), 64'(0));
        chk("t6_busy", 64'(busy), 64'(0));
        chk("t6_errcnt", 64'(err_cnt), 64'(0));
        chk("t6_no_rsp", 64'(rsp_valid), 64'(0));
        wait_k    = 1;
        req_write = 2'b11;
        req_addr  = {32'h34, 32'h30};
        req_wdata = {32'h88, 32'h77};
        req_valid = 2'b11;
        #1;
        chk("t6_prio0", 64'(req_ready), 64'(2'b01));
        push_exp(2'b01, 32'h0, 1'b0);
        push_exp(2'b10, 32'h0, 1'b0);
        @(negedge pclk);
        req_valid[0] = 1'b0;
        chk("t6_pwdata", 64'(pwdata), 64'(32'h77));
        n = 0;
        #1;
        while (!req_ready[1] && n < 100) begin
            @(negedge pclk);
            #1;
            n++;
        end
        chk("t6_req1_ready", 64'(req_ready), 64'(2'b10));
        @(negedge pclk);
        req_valid[1] = 1'b0;
        wait_idle();

        repeat (3) @(negedge pclk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_rr_master.md
# apb_rr_master

Round-robin APB master that shares one APB slave port (the register-block slaves on our peripheral bus) between N_REQ on-chip requesters. Each requester issues single read/write commands over a valid/ready command channel. The block arbitrates between them and sequences the APB SETUP/ACCESS phases, including wait states and a pready timeout. It then returns read data and error status to the granted requester as a one-cycle response pulse.

## Interface
- N_REQ, 2, number of requesters (2..8)
- TIMEOUT_CYC, 16, maximum ACCESS cycles without pready before the transfer is aborted (1..255)
- pclk  in  1  clock; all logic rising-edge
- preset  in  1  reset; one clock, reset is synchronous and active-high
- req_valid  in  N_REQ  per-requester command valid
- req_ready  out  N_REQ  per-requester command accepted (one-hot, same-cycle handshake)
- req_write  in  N_REQ  per-requester 1=write, 0=read
- req_addr  in  32*N_REQ  per-requester address, requester i at bits [32i+31:32i]
- req_wdata  in  32*N_REQ  per-requester write data, same packing
- rsp_valid  out  N_REQ  one-cycle response pulse to the granted requester
- rsp_rdata  out  32  read data (0 for writes and errors)
- rsp_err  out  1  slave pslverr or timeout, valid with rsp_valid
- busy  out  1  high in any state other than IDLE
- err_cnt  out  8  saturating count of errored transfers
- psel, penable, pwrite  out  1  APB control
- paddr, pwdata  out  32  APB address and write data
- pready, pslverr  in  1  APB slave status
- prdata  in  32  APB read data

## Operation
- The FSM has four states: IDLE, SETUP, ACCESS, RESP.
- **IDLE**
  - If any req_valid bit is set, select the first set bit searching upward from last_grant+1 (modulo N_REQ).
  - Assert req_ready for the selected bit (combinational, only in IDLE).
  - Latch write/addr/wdata and the grant index; update last_grant; go to SETUP.
- **SETUP**
  - psel=1, penable=0; paddr, pwrite, pwdata driven from the latched command.
  - pwdata=0 for reads.
  - Clear the timeout counter; go to ACCESS.
- **ACCESS**
  - psel=1, penable=1.
  - If pready=1: capture prdata (reads only) and pslverr, then go to RESP.
  - If pready=0: increment the counter. When the counter reaches TIMEOUT_CYC, go to RESP with error=1 and rdata=0.
  - pslverr is sampled only in the cycle pready=1; the slave may hold it high outside transfers, and it is ignored there.
- **RESP**
  - psel=0, penable=0.
  - rsp_valid[grant]=1 for exactly one cycle with rsp_rdata/rsp_err.
  - err_cnt increments if error and err_cnt≠255.
  - Go to IDLE.
- paddr/pwrite/pwdata hold their last values outside SETUP/ACCESS. They are stable from SETUP through the end of ACCESS.
- last_grant resets to N_REQ-1, so requester 0 wins the first arbitration.
- Requests arriving while busy wait; req_valid must stay high until req_ready is seen.
- Timeout counter width: $clog2(TIMEOUT_CYC+1).

## Timing
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, err_cnt=0, busy=0, state IDLE.
- req_ready is forced 0 while preset=1.
- Accept in cycle T, SETUP in T+1, ACCESS from T+2.
- With the slave returning pready in ACCESS cycle k (k≥1), rsp_valid fires at T+2+k.
- With a one-wait-state slave: rsp_valid at T+4, 5 cycles per transfer including IDLE.
- Next accept no earlier than the cycle after RESP (no IDLE bypass).
- Timeout: with no pready, ACCESS lasts exactly TIMEOUT_CYC cycles.
- pready=1 in the cycle the counter reaches TIMEOUT_CYC: this is treated as a normal completion, not a timeout.
- Reset during SETUP/ACCESS/RESP:
  - Next cycle psel=penable=0 and no rsp_valid.
  - The accepted command is dropped; the requester reissues.
- Simultaneous req_valid from all requesters: strict rotation, no requester granted twice before all others are served.

## Test plan
- Req0 writes 0xDEADBEEF to 0x0, slave pready in 2nd ACCESS cycle -> T+1 psel=1 penable=0 paddr=0x0 pwrite=1 pwdata=0xDEADBEEF; T+2..T+3 penable=1; rsp_valid=01 at T+4, rsp_err=0, rsp_rdata=0.
- Req1 reads 0x4, slave returns prdata=0x5555_5555 with pready -> rsp_valid=10, rsp_rdata=0x5555_5555, rsp_err=0.
- Req0 reads 0x10, slave pready=1 pslverr=1 -> rsp_err=1, rsp_rdata=0, err_cnt=1; a following good transfer with stale pslverr=1 outside pready -> rsp_err=0.
- Both requesters hold req_valid for 4 transfers after reset -> req_ready sequence 01,10,01,10.
- Slave never asserts pready, TIMEOUT_CYC=16 -> penable high for exactly 16 cycles, then rsp_err=1, rsp_rdata=0, psel=0 in RESP.
- preset pulsed in 2nd ACCESS cycle -> next cycle psel=0, penable=0, busy=0, err_cnt=0, no rsp_valid; re-issued request accepted normally with requester 0 priority.
